// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Contents: instruction width, PC increment, FSM state type and the
// {instr, pc4} entry stored in both the instruction FIFO and the tag queue.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t, DEPTH entries (power of 2).
// Ports:
//   Clk, Rst        clock, asynchronous active-low reset
//   push, wdata     write request and entry
//   pop, rdata      read request and head entry (rdata valid when !empty)
//   clear           empties the FIFO; overrides push/pop that cycle
//   full, empty     status
//   count           number of stored entries, 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         clear,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage feeding the IF/ID register.
// Owns the fetch PC, issues in-order word requests to instruction memory,
// buffers {instruction, PC+4} in a FIFO and hands the head to IF/ID.
// A redirect from ID flushes the FIFO and discards responses still in flight.
// Ports:
//   Clk, Rst                        clock, asynchronous active-low reset
//   Redirect, RedirectPC            taken branch/jump pulse and target
//   Imem_ReqValid/Ready/Addr        request channel to instruction memory
//   Imem_RspValid/RspData           in-order response channel
//   IF_Valid/Ready                  head handshake towards IF/ID
//   IF_Instruction, IF_PCAddResult  head contents (0 when IF_Valid=0)
// Build option: define FETCHQ_BYPASS_EN to forward a response straight to
// IF/ID when the FIFO is empty (zero-cycle latency).
//
// state | meaning
// FETCH | issuing requests under the credit limit, responses enter the FIFO
// FLUSH | after a redirect, discarding responses owed to the old stream
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Imem_ReqValid,
    input  logic        Imem_ReqReady,
    output logic [31:0] Imem_ReqAddr,
    input  logic        Imem_RspValid,
    input  logic [31:0] Imem_RspData,
    output logic        IF_Valid,
    input  logic        IF_Ready,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PCAddResult
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t   state;
    logic [31:0]    pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  drop_next;
    logic [CW-1:0]  data_count;
    logic [CW-1:0]  tag_count;
    logic [CW:0]    in_use;
    fetch_entry_t   data_head;
    fetch_entry_t   tag_head;
    fetch_entry_t   tag_in;
    fetch_entry_t   rsp_entry;
    logic           data_full, data_empty, tag_full, tag_empty;
    logic           req_fire, rsp_live, fifo_valid, bypass;
    logic           data_push, data_pop;
    logic           unused_fifo_status;

    // Credit: buffered entries plus requests in flight never exceed DEPTH,
    // so every response has a FIFO slot waiting for it. Rst gates the
    // request so nothing is offered while reset is held.
    assign in_use        = {1'b0, data_count} + {1'b0, outstanding};
    assign Imem_ReqValid = Rst && (state == FETCH) && !Redirect && (in_use < DEPTH_W);
    assign Imem_ReqAddr  = pc;
    assign req_fire      = Imem_ReqValid && Imem_ReqReady;

    assign rsp_live   = Imem_RspValid && (state == FETCH) && !Redirect;
    assign tag_in     = '{instr: '0, pc4: pc + PC_INC};
    assign rsp_entry  = '{instr: Imem_RspData, pc4: tag_head.pc4};
    assign fifo_valid = !data_empty && !Redirect;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = rsp_live && data_empty;
`else
    assign bypass = 1'b0;
`endif

    assign IF_Valid  = fifo_valid || bypass;
    assign data_pop  = fifo_valid && IF_Ready;
    assign data_push = rsp_live && !(bypass && IF_Ready);

    always_comb begin
        IF_Instruction = '0;
        IF_PCAddResult = '0;
        if (bypass) begin
            IF_Instruction = Imem_RspData;
            IF_PCAddResult = tag_head.pc4;
        end else if (fifo_valid) begin
            IF_Instruction = data_head.instr;
            IF_PCAddResult = data_head.pc4;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_data_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (data_push),
        .wdata (rsp_entry),
        .pop   (data_pop),
        .clear (Redirect),
        .rdata (data_head),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    // PC+4 of each live request, popped as its response returns.
    fetch_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (req_fire),
        .wdata (tag_in),
        .pop   (rsp_live),
        .clear (Redirect),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // The credit rule makes these status outputs redundant here.
    assign unused_fifo_status = ^{data_full, tag_full, tag_empty, tag_count, tag_head.instr};

    // Responses arriving in the redirect cycle belong to the old stream and
    // are already paid off, so they are not counted in drop_cnt.
    assign drop_next = outstanding - CW'(Imem_RspValid);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(Imem_RspValid);
            if (Redirect) begin
                pc       <= {RedirectPC[31:2], 2'b00};
                drop_cnt <= drop_next;
                state    <= (drop_next != '0) ? FLUSH : FETCH;
            end else begin
                if (req_fire) pc <= pc + PC_INC;
                if ((state == FLUSH) && Imem_RspValid) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1)) state <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a transaction-level model:
// a memory queue of in-flight requests (live or stale) and a queue of
// delivered-but-unconsumed fetch addresses.
module tb_fetch_prefetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        Imem_ReqValid;
    logic        Imem_ReqReady = 1'b0;
    logic [31:0] Imem_ReqAddr;
    logic        Imem_RspValid = 1'b0;
    logic [31:0] Imem_RspData = '0;
    logic        IF_Valid;
    logic        IF_Ready = 1'b0;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCAddResult;

    always #5 Clk = ~Clk;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Redirect       (Redirect),
        .RedirectPC     (RedirectPC),
        .Imem_ReqValid  (Imem_ReqValid),
        .Imem_ReqReady  (Imem_ReqReady),
        .Imem_ReqAddr   (Imem_ReqAddr),
        .Imem_RspValid  (Imem_RspValid),
        .Imem_RspData   (Imem_RspData),
        .IF_Valid       (IF_Valid),
        .IF_Ready       (IF_Ready),
        .IF_Instruction (IF_Instruction),
        .IF_PCAddResult (IF_PCAddResult)
    );

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          rdy;
    } mem_txn_t;

    mem_txn_t    memq[$];
    logic [31:0] expq[$];
    logic [31:0] mpc;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    int          lat_min = 1, lat_max = 1;
    int          p_ready = 100, p_ifr = 100, p_redir = 0, p_rsp = 100;
    bit          force_redir = 0;
    logic [31:0] force_tgt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic drive_idle();
        Redirect      = 1'b0;
        Imem_ReqReady = 1'b0;
        Imem_RspValid = 1'b0;
        IF_Ready      = 1'b0;
    endtask

    task automatic step();
        int          n_exp, n_out, n_dead;
        bit          rsp, live_rsp, exp_v;
        mem_txn_t    e;
        mem_txn_t    nt;
        logic [31:0] tgt, hd;
        @(negedge Clk);
        n_exp  = expq.size();
        n_out  = memq.size();
        n_dead = 0;
        foreach (memq[i]) if (!memq[i].live) n_dead++;

        Redirect = force_redir || ($urandom_range(99) < p_redir);
        if (force_redir) tgt = force_tgt;
        else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(15);
        else tgt = $urandom;
        RedirectPC    = tgt;
        Imem_ReqReady = ($urandom_range(99) < p_ready);
        IF_Ready      = ($urandom_range(99) < p_ifr);
        rsp = (memq.size() > 0) && (memq[0].rdy <= cyc) && ($urandom_range(99) < p_rsp);
        e = '{addr: 32'h0, live: 1'b0, rdy: 0};
        if (rsp) begin
            e = memq.pop_front();
            Imem_RspData = mem_word(e.addr);
        end else begin
            Imem_RspData = $urandom;
        end
        Imem_RspValid = rsp;
        live_rsp = rsp && e.live && !Redirect;
        #1;

        exp_v = (n_exp > 0) && !Redirect;
        hd    = (n_exp > 0) ? expq[0] : 32'h0;
`ifdef FETCHQ_BYPASS_EN
        if ((n_exp == 0) && live_rsp) begin
            exp_v = 1'b1;
            hd    = e.addr;
        end
`endif
        check_eq("if_valid", IF_Valid, exp_v);
        check_eq("if_instr", IF_Instruction, exp_v ? mem_word(hd) : 32'h0);
        check_eq("if_pc4", IF_PCAddResult, exp_v ? hd + 32'd4 : 32'h0);
        check_eq("req_valid", Imem_ReqValid,
                 (!Redirect && (n_dead == 0) && (n_exp + n_out < DEPTH)));
        if (Imem_ReqValid) check_eq("req_addr", Imem_ReqAddr, mpc);

        if (Redirect) begin
            expq.delete();
            foreach (memq[i]) memq[i].live = 1'b0;
            mpc = {tgt[31:2], 2'b00};
        end else begin
            if (live_rsp) expq.push_back(e.addr);
            if (exp_v && IF_Ready) void'(expq.pop_front());
        end
        if (Imem_ReqValid && Imem_ReqReady) begin
            nt.addr = mpc;
            nt.live = 1'b1;
            nt.rdy  = cyc + $urandom_range(lat_max, lat_min);
            memq.push_back(nt);
            mpc = mpc + 32'd4;
        end
        force_redir = 0;
        cyc++;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int ifr,
                             input int redir, input int rspp);
        lat_min = lmin; lat_max = lmax; p_ready = rdy;
        p_ifr = ifr; p_redir = redir; p_rsp = rspp;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        force_redir = 1;
        force_tgt   = t;
        step();
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_req_valid"}, Imem_ReqValid, 32'h0);
        check_eq({tag, "_req_addr"}, Imem_ReqAddr, RESET_PC);
        check_eq({tag, "_if_valid"}, IF_Valid, 32'h0);
        check_eq({tag, "_if_instr"}, IF_Instruction, 32'h0);
        check_eq({tag, "_if_pc4"}, IF_PCAddResult, 32'h0);
    endtask

    initial begin
        drive_idle();
        mpc = RESET_PC;
        #1;
        reset_checks("rst");
        #20;
        @(negedge Clk);
        Rst = 1'b1;

        // straight-line stream, 1-cycle memory, consumer always ready
        set_knobs(1, 1, 100, 100, 0, 100);
        repeat (20) step();

        // consumer stall: FIFO fills to the credit limit, then drains in order
        p_ifr = 0;
        repeat (12) step();
        p_ifr = 100;
        repeat (12) step();

        // 3-cycle memory, redirect with requests in flight
        set_knobs(3, 3, 100, 100, 0, 100);
        repeat (4) step();
        redirect_to(32'h0000_0100);
        repeat (15) step();

        // wrap at the top of the address space
        set_knobs(1, 1, 100, 100, 0, 100);
        redirect_to(32'hFFFF_FFF8);
        repeat (12) step();

        // reset asserted while flushing with responses still owed
        set_knobs(6, 6, 100, 100, 0, 0);
        repeat (2) step();
        redirect_to(32'h0000_0300);
        step();
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        drive_idle();
        #1;
        reset_checks("midrst");
        memq.delete();
        expq.delete();
        mpc = RESET_PC;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        set_knobs(1, 2, 100, 100, 0, 100);
        repeat (10) step();

        // randomized traffic with knobs reshuffled periodically
        for (int blk = 0; blk < 16; blk++) begin
            set_knobs(1, $urandom_range(5, 1), $urandom_range(100, 30), $urandom_range(100, 0),
                      $urandom_range(10, 0), $urandom_range(100, 50));
            repeat (150) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
